usb_tx_sched: RTL and testbench

Packet scheduler in front of the `usb_tx` serializer. It arbitrates between two requesters: the protocol engine, which sends handshakes, and the endpoint buffer, which sends DATA0/DATA1 packets. It generates the PID byte and sequences payload bytes against the serializer's `data_strobe`. It also controls CRC16 insertion, detects end of packet and enforces the inter-packet gap before the next grant.

---
 rtl/usb_pkg.sv | 45 ++++
 rtl/usb_tx_toggle.sv | 51 +++++
 rtl/usb_tx_sched.sv | 211 +++++++++++++++++++++
 tb/tb_usb_tx_sched.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// -----------------------------------------------------------------------------
// usb_pkg
// Shared definitions for the USB full-speed transmit path.
//   - 4-bit PID codes for the packets the scheduler can emit
//   - handshake request code enumeration (hs_code input of usb_tx_sched)
//   - scheduler FSM state encoding
//   - helpers mapping a handshake code to its PID and a PID to its line byte
// -----------------------------------------------------------------------------
package usb_pkg;

    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;

    typedef enum logic [1:0] {
        HS_ACK       = 2'b00,
        HS_NAK       = 2'b01,
        HS_STALL     = 2'b10,
        HS_STALL_ALT = 2'b11
    } hs_code_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PID      = 3'd1,
        ST_PAYLOAD  = 3'd2,
        ST_WAIT_EOP = 3'd3,
        ST_GAP      = 3'd4
    } sched_state_e;

    function automatic logic [3:0] hs_pid(input logic [1:0] code);
        case (code)
            HS_ACK:  return PID_ACK;
            HS_NAK:  return PID_NAK;
            default: return PID_STALL;
        endcase
    endfunction

    // The PID byte carries its own complement in the upper nibble.
    function automatic logic [7:0] pid_byte(input logic [3:0] pid);
        return {~pid, pid};
    endfunction

endpackage

// File: rtl/usb_tx_toggle.sv
// -----------------------------------------------------------------------------
// usb_tx_toggle
// Per-endpoint DATA0/DATA1 toggle table (one bit per endpoint).
// Ports:
//   clk_48, rst_n      clock, asynchronous active-low reset (clears all bits)
//   tog_ack, tog_ep    flip the bit of endpoint tog_ep
//   tog_clr            zero the bit of endpoint tog_ep (wins over tog_ack)
//   rd_ep, rd_bit      combinational read port: current toggle of rd_ep
// A read in the same cycle as an update returns the old value, so an update
// coinciding with a grant applies to the following packet.
// -----------------------------------------------------------------------------
module usb_tx_toggle #(
    parameter int EP_W = 4
) (
    input  logic            clk_48,
    input  logic            rst_n,
    input  logic            tog_ack,
    input  logic            tog_clr,
    input  logic [EP_W-1:0] tog_ep,
    input  logic [EP_W-1:0] rd_ep,
    output logic            rd_bit
);

    localparam int N_EP = 1 << EP_W;

    logic [N_EP-1:0] w_tog;

    generate
        for (genvar gi = 0; gi < N_EP; gi++) begin : g_ep
            logic r_bit;
            logic w_sel;

            assign w_sel = (tog_ep == EP_W'(gi));

            always_ff @(posedge clk_48 or negedge rst_n) begin
                if (!rst_n) begin
                    r_bit <= 1'b0;
                end else if (w_sel && tog_clr) begin
                    r_bit <= 1'b0;
                end else if (w_sel && tog_ack) begin
                    r_bit <= ~r_bit;
                end
            end

            assign w_tog[gi] = r_bit;
        end
    endgenerate

    assign rd_bit = w_tog[rd_ep];

endmodule

// File: rtl/usb_tx_sched.sv
// -----------------------------------------------------------------------------
// usb_tx_sched
// Packet scheduler in front of the usb_tx serializer. Arbitrates handshake
// (priority) versus data requests, emits the PID byte, streams payload bytes
// on tx_data_strobe, controls CRC16 insertion, waits for end of packet and
// enforces an idle gap before the next grant.
// Optional feature: define USB_TX_SCHED_TOGGLE_EN to pick DATA0/DATA1 from an
// internal per-endpoint toggle table instead of dat_pid1.
// Ports:
//   clk_48, rst_n                       clock, asynchronous active-low reset
//   hs_req, hs_code, hs_done            handshake request / code / done pulse
//   dat_req, dat_ep, dat_pid1, dat_len  data request and its attributes
//   dat_byte, dat_byte_rd               FWFT payload byte and its consume pulse
//   dat_done                            data packet done pulse
//   tog_ack, tog_clr, tog_ep            toggle table updates (feature only)
//   tx_transmit, tx_data,
//   tx_update_crc16, tx_send_crc16      serializer controls
//   tx_data_strobe, tx_en               serializer status
//   busy                                scheduler not idle
// -----------------------------------------------------------------------------
module usb_tx_sched
    import usb_pkg::*;
#(
    parameter int LEN_W      = 7,
    parameter int EP_W       = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic             clk_48,
    input  logic             rst_n,
    input  logic             hs_req,
    input  logic [1:0]       hs_code,
    output logic             hs_done,
    input  logic             dat_req,
    input  logic [EP_W-1:0]  dat_ep,
    input  logic             dat_pid1,
    input  logic [LEN_W-1:0] dat_len,
    input  logic [7:0]       dat_byte,
    output logic             dat_byte_rd,
    output logic             dat_done,
    input  logic             tog_ack,
    input  logic             tog_clr,
    input  logic [EP_W-1:0]  tog_ep,
    output logic             tx_transmit,
    output logic [7:0]       tx_data,
    output logic             tx_update_crc16,
    output logic             tx_send_crc16,
    input  logic             tx_data_strobe,
    input  logic             tx_en,
    output logic             busy
);

    localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

    sched_state_e     r_state, w_state_next;
    logic             r_is_dat;
    logic [3:0]       r_pid;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic [GAP_W-1:0] r_gap;
    logic             r_tx_transmit;
    logic             r_hs_done;
    logic             r_dat_done;

    logic             w_grant;
    logic             w_clr_tx;
    logic             w_load_cnt;
    logic             w_dec_cnt;
    logic             w_done;
    logic             w_load_gap;
    logic             w_dat_is_pid1;
    logic [7:0]       w_tx_data;
    logic             w_update_crc;
    logic             w_byte_rd;

`ifdef USB_TX_SCHED_TOGGLE_EN
    logic w_unused_cfg;
    assign w_unused_cfg = dat_pid1;

    usb_tx_toggle #(
        .EP_W (EP_W)
    ) u_toggle (
        .clk_48  (clk_48),
        .rst_n   (rst_n),
        .tog_ack (tog_ack),
        .tog_clr (tog_clr),
        .tog_ep  (tog_ep),
        .rd_ep   (dat_ep),
        .rd_bit  (w_dat_is_pid1)
    );
`else
    logic w_unused_cfg;
    assign w_unused_cfg  = ^{dat_ep, tog_ack, tog_clr, tog_ep};
    assign w_dat_is_pid1 = dat_pid1;
`endif

    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_clr_tx     = 1'b0;
        w_load_cnt   = 1'b0;
        w_dec_cnt    = 1'b0;
        w_done       = 1'b0;
        w_load_gap   = 1'b0;
        w_tx_data    = 8'h00;
        w_update_crc = 1'b0;
        w_byte_rd    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A still-busy serializer blocks new grants.
                if (!tx_en && (hs_req || dat_req)) begin
                    w_grant      = 1'b1;
                    w_state_next = ST_PID;
                end
            end
            ST_PID: begin
                w_tx_data = pid_byte(r_pid);
                if (tx_data_strobe) begin
                    if (!r_is_dat || (r_len == '0)) begin
                        w_clr_tx     = 1'b1;
                        w_state_next = ST_WAIT_EOP;
                    end else begin
                        w_load_cnt   = 1'b1;
                        w_state_next = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                w_tx_data    = dat_byte;
                w_update_crc = 1'b1;
                w_byte_rd    = tx_data_strobe;
                if (tx_data_strobe) begin
                    w_dec_cnt = 1'b1;
                    if (r_cnt == LEN_W'(1)) begin
                        w_clr_tx     = 1'b1;
                        w_state_next = ST_WAIT_EOP;
                    end
                end
            end
            ST_WAIT_EOP: begin
                if (!tx_en) begin
                    w_done       = 1'b1;
                    w_load_gap   = 1'b1;
                    w_state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_gap <= GAP_W'(1)) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_48 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_48 or negedge rst_n) begin
        if (!rst_n) begin
            r_is_dat      <= 1'b0;
            r_pid         <= 4'h0;
            r_len         <= '0;
            r_cnt         <= '0;
            r_gap         <= '0;
            r_tx_transmit <= 1'b0;
            r_hs_done     <= 1'b0;
            r_dat_done    <= 1'b0;
        end else begin
            r_hs_done  <= w_done & ~r_is_dat;
            r_dat_done <= w_done & r_is_dat;

            if (w_grant) begin
                r_is_dat      <= ~hs_req;
                r_pid         <= hs_req ? hs_pid(hs_code)
                                        : (w_dat_is_pid1 ? PID_DATA1 : PID_DATA0);
                r_len         <= hs_req ? '0 : dat_len;
                r_tx_transmit <= 1'b1;
            end else if (w_clr_tx) begin
                r_tx_transmit <= 1'b0;
            end

            if (w_load_cnt) begin
                r_cnt <= r_len;
            end else if (w_dec_cnt) begin
                r_cnt <= r_cnt - LEN_W'(1);
            end

            if (w_load_gap) begin
                r_gap <= GAP_W'(GAP_CYCLES);
            end else if ((r_state == ST_GAP) && (r_gap != '0)) begin
                r_gap <= r_gap - GAP_W'(1);
            end
        end
    end

    assign tx_transmit     = r_tx_transmit;
    assign tx_data         = w_tx_data;
    assign tx_update_crc16 = w_update_crc;
    // Held for the whole packet life so the serializer sees a stable value.
    assign tx_send_crc16   = r_is_dat && (r_state != ST_IDLE);
    assign dat_byte_rd     = w_byte_rd;
    assign hs_done         = r_hs_done;
    assign dat_done        = r_dat_done;
    assign busy            = (r_state != ST_IDLE);

endmodule

// File: tb/tb_usb_tx_sched.sv
// -----------------------------------------------------------------------------
// tb_usb_tx_sched
// Directed bench for usb_tx_sched with a small behavioural serializer and a
// scoreboard of expected line bytes and done pulses.
// -----------------------------------------------------------------------------
module tb_usb_tx_sched;

    localparam int LEN_W      = 7;
    localparam int EP_W       = 4;
    localparam int GAP_CYCLES = 8;
    localparam int BYTE_CYC   = 8;

    typedef struct {
        logic [7:0] data;
        logic       rd;
        logic       upd;
        logic       crc;
        logic       last;
    } exp_t;

    logic             clk_48 = 1'b0;
    logic             rst_n;
    logic             hs_req;
    logic [1:0]       hs_code;
    logic             hs_done;
    logic             dat_req;
    logic [EP_W-1:0]  dat_ep;
    logic             dat_pid1;
    logic [LEN_W-1:0] dat_len;
    logic [7:0]       dat_byte;
    logic             dat_byte_rd;
    logic             dat_done;
    logic             tog_ack;
    logic             tog_clr;
    logic [EP_W-1:0]  tog_ep;
    logic             tx_transmit;
    logic [7:0]       tx_data;
    logic             tx_update_crc16;
    logic             tx_send_crc16;
    logic             tx_data_strobe;
    logic             tx_en;
    logic             busy;

    exp_t       exp_q[$];
    logic [1:0] done_q[$];
    logic [7:0] pay[0:128];

    int n_tests  = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int fall_cyc = -100;
    int ser_ph   = 0;
    int ser_cnt  = 0;
    int rd_idx   = 0;
    bit chk_low  = 1'b0;

    always #5 clk_48 = ~clk_48;

    usb_tx_sched #(
        .LEN_W      (LEN_W),
        .EP_W       (EP_W),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk_48          (clk_48),
        .rst_n           (rst_n),
        .hs_req          (hs_req),
        .hs_code         (hs_code),
        .hs_done         (hs_done),
        .dat_req         (dat_req),
        .dat_ep          (dat_ep),
        .dat_pid1        (dat_pid1),
        .dat_len         (dat_len),
        .dat_byte        (dat_byte),
        .dat_byte_rd     (dat_byte_rd),
        .dat_done        (dat_done),
        .tog_ack         (tog_ack),
        .tog_clr         (tog_clr),
        .tog_ep          (tog_ep),
        .tx_transmit     (tx_transmit),
        .tx_data         (tx_data),
        .tx_update_crc16 (tx_update_crc16),
        .tx_send_crc16   (tx_send_crc16),
        .tx_data_strobe  (tx_data_strobe),
        .tx_en           (tx_en),
        .busy            (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock of the serializer model plus scoreboard checks.
    task automatic step();
        exp_t       e;
        logic [1:0] de;
        @(posedge clk_48);
        #1;
        cyc++;
        tx_data_strobe = 1'b0;
        if (chk_low) begin
            check("tx_transmit_low_after_last", {31'd0, tx_transmit}, 32'd0);
            chk_low = 1'b0;
        end
        if (hs_done || dat_done) begin
            de = (done_q.size() > 0) ? done_q.pop_front() : 2'b00;
            check("done_kind", {30'd0, hs_done, dat_done}, {30'd0, de});
            check("done_latency", cyc - fall_cyc, 32'd1);
            $display("[TB] cyc %0d done hs=%0b dat=%0b", cyc, hs_done, dat_done);
            if (hs_done)  hs_req  = 1'b0;
            if (dat_done) dat_req = 1'b0;
        end
        case (ser_ph)
            0: if (tx_transmit) begin
                check("grant_gap", {31'd0, (cyc - fall_cyc) >= GAP_CYCLES + 1}, 32'd1);
                tx_en    = 1'b1;
                ser_ph   = 1;
                ser_cnt  = BYTE_CYC;
                rd_idx   = 0;
                dat_byte = pay[0];
            end
            1: begin
                ser_cnt--;
                if (ser_cnt == 0) begin
                    if (tx_transmit) begin
                        tx_data_strobe = 1'b1;
                        ser_cnt        = BYTE_CYC;
                    end else if (tx_send_crc16) begin
                        ser_ph  = 2;
                        ser_cnt = 2 * BYTE_CYC;
                    end else begin
                        ser_ph  = 3;
                        ser_cnt = 4;
                    end
                end
            end
            2: begin
                ser_cnt--;
                if (ser_cnt == 0) begin
                    ser_ph  = 3;
                    ser_cnt = 4;
                end
            end
            3: begin
                ser_cnt--;
                if (ser_cnt == 0) begin
                    tx_en    = 1'b0;
                    ser_ph   = 0;
                    fall_cyc = cyc;
                end
            end
            default: ser_ph = 0;
        endcase
        if (tx_data_strobe) begin
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
            end else begin
                e = '{data: 8'hxx, rd: 1'bx, upd: 1'bx, crc: 1'bx, last: 1'b0};
            end
            $display("[TB] cyc %0d strobe data=%02h rd=%0b upd=%0b crc=%0b",
                     cyc, tx_data, dat_byte_rd, tx_update_crc16, tx_send_crc16);
            check("tx_data",         {24'd0, tx_data},         {24'd0, e.data});
            check("dat_byte_rd",     {31'd0, dat_byte_rd},     {31'd0, e.rd});
            check("tx_update_crc16", {31'd0, tx_update_crc16}, {31'd0, e.upd});
            check("tx_send_crc16",   {31'd0, tx_send_crc16},   {31'd0, e.crc});
            if (e.last) chk_low = 1'b1;
            if (dat_byte_rd) begin
                rd_idx++;
                dat_byte = pay[rd_idx];
            end
        end
    endtask

    task automatic run_idle(input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while ((busy || tx_en || done_q.size() > 0 || exp_q.size() > 0) && n < 4000);
        check({tag, "_timeout"}, {31'd0, n < 4000}, 32'd1);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic push_hs(input logic [7:0] pidb);
        exp_q.push_back('{data: pidb, rd: 1'b0, upd: 1'b0, crc: 1'b0, last: 1'b1});
        done_q.push_back(2'b10);
    endtask

    task automatic push_dat(input int len, input logic [7:0] pidb, input logic [7:0] seed);
        for (int i = 0; i < len; i++) pay[i] = seed + 8'(i * 7);
        pay[len] = 8'hEE;
        exp_q.push_back('{data: pidb, rd: 1'b0, upd: 1'b0, crc: 1'b1, last: (len == 0)});
        for (int i = 0; i < len; i++)
            exp_q.push_back('{data: pay[i], rd: 1'b1, upd: 1'b1, crc: 1'b1, last: (i == len - 1)});
        done_q.push_back(2'b01);
    endtask

    task automatic do_hs(input logic [1:0] code, input logic [7:0] pidb, input string tag);
        push_hs(pidb);
        hs_code = code;
        hs_req  = 1'b1;
        run_idle(tag);
    endtask

    task automatic do_dat(input int len, input logic p1, input logic [EP_W-1:0] ep,
                          input logic [7:0] pidb, input logic [7:0] seed, input string tag);
        push_dat(len, pidb, seed);
        dat_len  = LEN_W'(len);
        dat_pid1 = p1;
        dat_ep   = ep;
        dat_req  = 1'b1;
        run_idle(tag);
    endtask

    initial begin
        rst_n = 1'b0; hs_req = 1'b0; hs_code = 2'b00; dat_req = 1'b0;
        dat_ep = '0; dat_pid1 = 1'b0; dat_len = '0; dat_byte = 8'h00;
        tog_ack = 1'b0; tog_clr = 1'b0; tog_ep = '0;
        tx_data_strobe = 1'b0; tx_en = 1'b0;
        for (int i = 0; i <= 128; i++) pay[i] = 8'h00;

        // Reset state
        repeat (2) @(posedge clk_48);
        #1;
        check("rst_tx_transmit", {31'd0, tx_transmit}, 32'd0);
        check("rst_tx_data",     {24'd0, tx_data},     32'd0);
        check("rst_send_crc",    {31'd0, tx_send_crc16}, 32'd0);
        check("rst_busy",        {31'd0, busy},        32'd0);
        check("rst_done",        {30'd0, hs_done, dat_done}, 32'd0);
        @(negedge clk_48);
        rst_n = 1'b1;

        // Handshakes
        do_hs(2'b00, 8'hD2, "hs_ack");
        do_hs(2'b01, 8'h5A, "hs_nak");
        do_hs(2'b10, 8'h1E, "hs_stall");
        do_hs(2'b11, 8'h1E, "hs_stall_alt");

        // Data packet DATA1 with bytes 01 02 03
        push_dat(0, 8'h4B, 8'h00);
        exp_q.delete();
        done_q.delete();
        pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03; pay[3] = 8'hEE;
        exp_q.push_back('{data: 8'h4B, rd: 1'b0, upd: 1'b0, crc: 1'b1, last: 1'b0});
        exp_q.push_back('{data: 8'h01, rd: 1'b1, upd: 1'b1, crc: 1'b1, last: 1'b0});
        exp_q.push_back('{data: 8'h02, rd: 1'b1, upd: 1'b1, crc: 1'b1, last: 1'b0});
        exp_q.push_back('{data: 8'h03, rd: 1'b1, upd: 1'b1, crc: 1'b1, last: 1'b1});
        done_q.push_back(2'b01);
        dat_len = 7'd3; dat_pid1 = 1'b1; dat_ep = 4'd1; dat_req = 1'b1;
        run_idle("dat3");
        check("dat3_bytes_read", rd_idx, 32'd3);

        // Zero-length packet, DATA0
        do_dat(0, 1'b0, 4'd1, 8'hC3, 8'h00, "zlp");
        check("zlp_bytes_read", rd_idx, 32'd0);

        // Arbitration: simultaneous NAK and DATA0 request
        push_hs(8'h5A);
        push_dat(2, 8'hC3, 8'h40);
        hs_code = 2'b01; hs_req = 1'b1;
        dat_len = 7'd2; dat_pid1 = 1'b0; dat_req = 1'b1;
        run_idle("arb");

        // Maximum payload length must not wrap
        do_dat(127, 1'b1, 4'd5, 8'h4B, 8'h11, "max_len");
        check("max_len_bytes_read", rd_idx, 32'd127);

        // Reset in the middle of a 10-byte payload
        push_dat(10, 8'hC3, 8'h80);
        dat_len = 7'd10; dat_pid1 = 1'b0; dat_req = 1'b1;
        for (int n = 0; n < 2000 && rd_idx < 3; n++) step();
        check("mid_rst_reached_payload", {31'd0, rd_idx >= 3}, 32'd1);
        #2;
        rst_n = 1'b0;
        tx_data_strobe = 1'b0;
        #1;
        check("mid_rst_tx_transmit", {31'd0, tx_transmit},     32'd0);
        check("mid_rst_tx_data",     {24'd0, tx_data},         32'd0);
        check("mid_rst_update_crc",  {31'd0, tx_update_crc16}, 32'd0);
        check("mid_rst_send_crc",    {31'd0, tx_send_crc16},   32'd0);
        check("mid_rst_byte_rd",     {31'd0, dat_byte_rd},     32'd0);
        check("mid_rst_busy",        {31'd0, busy},            32'd0);
        check("mid_rst_done",        {30'd0, hs_done, dat_done}, 32'd0);
        exp_q.delete();
        done_q.delete();
        dat_req = 1'b0;
        tx_en   = 1'b0;
        ser_ph  = 0;
        chk_low = 1'b0;
        fall_cyc = cyc - 100;
        repeat (2) step();
        @(negedge clk_48);
        rst_n = 1'b1;
        repeat (12) step();
        check("post_rst_idle", {31'd0, busy}, 32'd0);
        do_hs(2'b00, 8'hD2, "post_rst_ack");

`ifdef USB_TX_SCHED_TOGGLE_EN
        // Toggle table: dat_pid1 driven high to show it is ignored
        do_dat(1, 1'b1, 4'd2, 8'hC3, 8'h21, "tog_ep2_d0");
        tog_ep = 4'd2; tog_ack = 1'b1;
        step();
        tog_ack = 1'b0;
        do_dat(1, 1'b1, 4'd2, 8'h4B, 8'h22, "tog_ep2_d1");
        do_dat(1, 1'b1, 4'd3, 8'hC3, 8'h23, "tog_ep3_d0");
        tog_ep = 4'd2; tog_ack = 1'b1; tog_clr = 1'b1;
        step();
        tog_ack = 1'b0; tog_clr = 1'b0;
        do_dat(1, 1'b1, 4'd2, 8'hC3, 8'h24, "tog_ep2_clr");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
